// File: rtl/breakout_motion_ctrl_pkg.sv
`default_nettype none
// ==== breakout_motion_ctrl_pkg : geometry, FSM states, direction encoding | rev 1.0 ====
package breakout_motion_ctrl_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int FRAME_LINE  = 480;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_W    = 64;
  localparam int PADDLE_H    = 8;
  localparam int PADDLE_Y    = 440;
  localparam int PADDLE_STEP = 4;
  localparam int BALL_STEP   = 2;
  localparam int START_LIVES = 3;

  // 11-bit signed so that a step past column/row 0 shows up as a negative value
  typedef logic signed [10:0] coord_t;

  localparam coord_t C_SCREEN_W     = coord_t'(SCREEN_W);
  localparam coord_t C_SCREEN_H     = coord_t'(SCREEN_H);
  localparam coord_t C_BALL_SIZE    = coord_t'(BALL_SIZE);
  localparam coord_t C_PADDLE_W     = coord_t'(PADDLE_W);
  localparam coord_t C_PADDLE_H     = coord_t'(PADDLE_H);
  localparam coord_t C_PADDLE_Y     = coord_t'(PADDLE_Y);
  localparam coord_t C_PADDLE_STEP  = coord_t'(PADDLE_STEP);
  localparam coord_t C_BALL_STEP    = coord_t'(BALL_STEP);
  localparam coord_t C_PADDLE_MAX   = coord_t'(SCREEN_W - PADDLE_W);
  localparam coord_t C_BALL_MAX_X   = coord_t'(SCREEN_W - BALL_SIZE);
  localparam coord_t C_PARK_Y       = coord_t'(PADDLE_Y - BALL_SIZE);
  localparam coord_t C_PARK_OFS     = coord_t'((PADDLE_W - BALL_SIZE) / 2);
  localparam coord_t C_PADDLE_RESET = coord_t'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [9:0] C_FRAME_LINE  = 10'(FRAME_LINE);
  localparam logic [1:0] C_START_LIVES = 2'(START_LIVES);

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PADDLE  = 3'd1,
    ST_BALL    = 3'd2,
    ST_COLLIDE = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  function automatic coord_t park_x(input coord_t pad);
    return pad + C_PARK_OFS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/breakout_motion_ctrl_tick.sv
`default_nettype none
// ==== frame_tick_detect : one-clock pulse on the first blank line of each frame | rev 1.0 ====
module frame_tick_detect
  import breakout_motion_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [9:0] pixelX_i,
  input  logic [9:0] pixelY_i,
  output logic       tick_o
);

  logic match_d;
  logic match_q;
  logic match_prev_q;

  assign match_d = (pixelX_i == 10'd0) && (pixelY_i == C_FRAME_LINE);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
    end else begin
      match_q      <= match_d;
      match_prev_q <= match_q;
    end
  end

  // pixelX sits at 0 for several system clocks; only the rising edge counts
  assign tick_o = match_q & ~match_prev_q;

endmodule
`default_nettype wire

// File: rtl/breakout_motion_ctrl.sv
`default_nettype none
// ==== breakout_motion_ctrl : per-frame paddle/ball/collision scheduler run in vblank | rev 1.0 ====
module breakout_motion_ctrl
  import breakout_motion_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [9:0] pixelX_i,
  input  logic [9:0] pixelY_i,
  input  logic       btnLeft_i,
  input  logic       btnRight_i,
  input  logic       btnLaunch_i,
  output logic [9:0] ballX_o,
  output logic [9:0] ballY_o,
  output logic [9:0] paddleX_o,
  output logic [1:0] lives_o,
  output logic       gameOver_o,
  output logic       updateBusy_o
);

  state_t     state_q, state_d;
  coord_t     pad_q, pad_d, nx_q, nx_d, ny_q, ny_d;
  logic       dx_q, dx_d, dy_q, dy_d;
  logic       serve_q, serve_d, launch_q, launch_d, miss_q, miss_d;
  logic [9:0] ballx_q, ballx_d, bally_q, bally_d, paddlex_q, paddlex_d;
  logic [1:0] lives_q, lives_d;
  logic       over_q, over_d;
  logic       tick;
  coord_t     cur_x, cur_y, cur_pad;
  logic       paddle_hit;

  frame_tick_detect u_tick (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .pixelX_i (pixelX_i),
    .pixelY_i (pixelY_i),
    .tick_o   (tick)
  );

  assign cur_x   = $signed({1'b0, ballx_q});
  assign cur_y   = $signed({1'b0, bally_q});
  assign cur_pad = $signed({1'b0, paddlex_q});

  assign paddle_hit = (ny_q + C_BALL_SIZE >= C_PADDLE_Y) && (ny_q <= C_PADDLE_Y + C_PADDLE_H) &&
                      (nx_q + C_BALL_SIZE > pad_q) && (nx_q < pad_q + C_PADDLE_W);

  always_comb begin
    state_d   = state_q;
    pad_d     = pad_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    serve_d   = serve_q;
    launch_d  = launch_q;
    miss_d    = miss_q;
    ballx_d   = ballx_q;
    bally_d   = bally_q;
    paddlex_d = paddlex_q;
    lives_d   = lives_q;
    over_d    = over_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && !over_q) state_d = ST_PADDLE;
      end
      ST_PADDLE: begin
        state_d = ST_BALL;
        pad_d   = cur_pad;
        if (btnLeft_i && !btnRight_i)
          pad_d = (cur_pad < C_PADDLE_STEP) ? '0 : cur_pad - C_PADDLE_STEP;
        else if (btnRight_i && !btnLeft_i)
          pad_d = (cur_pad > C_PADDLE_MAX - C_PADDLE_STEP) ? C_PADDLE_MAX : cur_pad + C_PADDLE_STEP;
      end
      ST_BALL: begin
        state_d  = ST_COLLIDE;
        launch_d = 1'b0;
        miss_d   = 1'b0;
        if (serve_q) begin
          nx_d = park_x(pad_q);
          ny_d = C_PARK_Y;
          if (btnLaunch_i) begin
            launch_d = 1'b1;
            dx_d     = DIR_POS;
            dy_d     = DIR_NEG;
          end
        end else begin
          nx_d = (dx_q == DIR_POS) ? cur_x + C_BALL_STEP : cur_x - C_BALL_STEP;
          ny_d = (dy_q == DIR_POS) ? cur_y + C_BALL_STEP : cur_y - C_BALL_STEP;
        end
      end
      ST_COLLIDE: begin
        state_d = ST_COMMIT;
        // serve_q is still set on the launch frame, so motion waits a frame
        if (!serve_q) begin
          if (nx_q[10]) begin
            nx_d = '0;
            dx_d = DIR_POS;
          end else if (nx_q + C_BALL_SIZE > C_SCREEN_W) begin
            nx_d = C_BALL_MAX_X;
            dx_d = DIR_NEG;
          end
          if (ny_q[10]) begin
            ny_d = '0;
            dy_d = DIR_POS;
          end else if (dy_q == DIR_POS && paddle_hit) begin
            ny_d = C_PARK_Y;
            dy_d = DIR_NEG;
          end
          if (ny_q >= C_SCREEN_H) begin
            miss_d = 1'b1;
            nx_d   = park_x(pad_q);
            ny_d   = C_PARK_Y;
            dx_d   = DIR_POS;
            dy_d   = DIR_NEG;
          end
        end
      end
      ST_COMMIT: begin
        state_d   = ST_IDLE;
        paddlex_d = pad_q[9:0];
        ballx_d   = nx_q[9:0];
        bally_d   = ny_q[9:0];
        serve_d   = miss_q | (serve_q & ~launch_q);
        launch_d  = 1'b0;
        miss_d    = 1'b0;
        if (miss_q) begin
          lives_d = lives_q - 2'd1;
          over_d  = (lives_q == 2'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pad_q     <= C_PADDLE_RESET;
      nx_q      <= park_x(C_PADDLE_RESET);
      ny_q      <= C_PARK_Y;
      dx_q      <= DIR_POS;
      dy_q      <= DIR_NEG;
      serve_q   <= 1'b1;
      launch_q  <= 1'b0;
      miss_q    <= 1'b0;
      paddlex_q <= C_PADDLE_RESET[9:0];
      ballx_q   <= park_x(C_PADDLE_RESET) & 11'h3FF;
      bally_q   <= C_PARK_Y[9:0];
      lives_q   <= C_START_LIVES;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_q     <= pad_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      serve_q   <= serve_d;
      launch_q  <= launch_d;
      miss_q    <= miss_d;
      paddlex_q <= paddlex_d;
      ballx_q   <= ballx_d;
      bally_q   <= bally_d;
      lives_q   <= lives_d;
      over_q    <= over_d;
    end
  end

  assign ballX_o      = ballx_q;
  assign ballY_o      = bally_q;
  assign paddleX_o    = paddlex_q;
  assign lives_o      = lives_q;
  assign gameOver_o   = over_q;
  assign updateBusy_o = (state_q != ST_IDLE);

endmodule
`default_nettype wire
